// File: rtl/fns_pkg.sv
// fns_pkg: Fibonacci-numeral constants shared by the FPF encoder.
// Every weight and threshold is derived from fns().
package fns_pkg;

   // k-th Fibonacci number, fns(1) = fns(2) = 1
   function automatic logic [63:0] fns(input int k);
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] t;
      a = 64'd1;
      b = 64'd1;
      for (int i = 3; i <= k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   // binary width able to carry every encodable value
   function automatic int fns_datalen(input int n);
      return $clog2(fns(n + 2));
   endfunction

   // sum of all bit weights of an n-bit codeword
   function automatic logic [63:0] fns_maxv(input int n);
      return fns(n + 2) - 64'd1;
   endfunction

   // bits owned by segment s; early segments take the remainder
   function automatic int seg_size(input int n, input int st, input int s);
      return n / st + ((s < n % st) ? 1 : 0);
   endfunction

   function automatic int seg_hi(input int n, input int st, input int s);
      int acc;
      acc = 0;
      for (int k = 0; k < s; k++) acc += seg_size(n, st, k);
      return n - 1 - acc;
   endfunction

   function automatic int seg_lo(input int n, input int st, input int s);
      return seg_hi(n, st, s) - seg_size(n, st, s) + 1;
   endfunction

endpackage

// File: rtl/fpf_enc_slice.sv
// fpf_enc_slice: combinational greedy-chain segment for bits HI..LO.
// The tie bit enters as c_prev and ripples down through the segment.
module fpf_enc_slice
   import fns_pkg::*;
#(
   parameter int CODE_W = 42,
   parameter int HI     = 41,
   parameter int LO     = 0,
   parameter int RW     = 30
) (
   input  logic [RW-1:0] rem_i,
   input  logic          c_prev_i,
   output logic [HI:LO]  code_o,
   output logic [RW-1:0] rem_o
);

   logic [63:0] r;
   logic        c;

   // decide each bit MSB first, subtracting its weight when set
   always_comb begin
      r      = 64'(rem_i);
      c      = c_prev_i;
      code_o = '0;
      for (int i = HI; i >= LO; i--) begin
         if (i == CODE_W - 1) begin
            c = (r >= fns(CODE_W + 1));
            if (c) r = r - fns(CODE_W);
         end else if (i == 0) begin
            c = r[0];
            r = '0;
         end else begin
            if (r < fns(i + 1))       c = 1'b0;
            else if (r >= fns(i + 2)) c = 1'b1;
            if (c) r = r - fns(i + 1);
         end
         code_o[i] = c;
      end
      rem_o = r[RW-1:0];
   end

endmodule

// File: rtl/fpf_encoder_pipe.sv
// fpf_encoder_pipe: pipelined FPF Fibonacci-numeral encoder with
// valid/ready flow control, sideband tag and out-of-range flag.
module fpf_encoder_pipe
   import fns_pkg::*;
#(
   parameter  int CODE_W = 42,
   parameter  int STAGES = 3,
   parameter  int TAG_W  = 4,
   localparam int DATA_W = fns_datalen(CODE_W)
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] datain,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] codeout,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   localparam logic [63:0] MAXV = fns_maxv(CODE_W);

   logic              adv;
   logic              in_err;
   logic [DATA_W-1:0] d_sat;
   logic              unused_tail;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // flag and clamp oversize words so they encode as all-ones
   always_comb begin
      in_err = 64'(datain) > MAXV;
      d_sat  = in_err ? MAXV[DATA_W-1:0] : datain;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int HI = seg_hi(CODE_W, STAGES, s);
      localparam int LO = seg_lo(CODE_W, STAGES, s);

      logic [DATA_W-1:0] rem_in, rem_nx, rem_d, rem_q;
      logic [CODE_W-1:0] code_in, code_d, code_q;
      logic [TAG_W-1:0]  tag_in, tag_d, tag_q;
      logic [HI:LO]      seg;
      logic              c_in, last_d, last_q;
      logic              err_in, err_d, err_q;
      logic              vld_in, vld_d, vld_q;

      if (s == 0) begin : g_head
         assign rem_in  = d_sat;
         assign c_in    = 1'b0;
         assign code_in = '0;
         assign tag_in  = in_tag;
         assign err_in  = in_err;
         assign vld_in  = in_valid;
      end else begin : g_body
         assign rem_in  = g_st[s-1].rem_q;
         assign c_in    = g_st[s-1].last_q;
         assign code_in = g_st[s-1].code_q;
         assign tag_in  = g_st[s-1].tag_q;
         assign err_in  = g_st[s-1].err_q;
         assign vld_in  = g_st[s-1].vld_q;
      end

      fpf_enc_slice #(
         .CODE_W (CODE_W),
         .HI     (HI),
         .LO     (LO),
         .RW     (DATA_W)
      ) u_slice (
         .rem_i    (rem_in),
         .c_prev_i (c_in),
         .code_o   (seg),
         .rem_o    (rem_nx)
      );

      // merge this segment's bits; hold the whole slot on a stall
      always_comb begin
         rem_d  = rem_q;
         code_d = code_q;
         last_d = last_q;
         tag_d  = tag_q;
         err_d  = err_q;
         vld_d  = vld_q;
         if (adv) begin
            rem_d          = rem_nx;
            code_d         = code_in;
            code_d[HI:LO]  = seg;
            last_d         = seg[LO];
            tag_d          = tag_in;
            err_d          = err_in;
            vld_d          = vld_in;
         end
      end

      // stage register; reset drops any word in flight
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            rem_q  <= '0;
            code_q <= '0;
            last_q <= 1'b0;
            tag_q  <= '0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
         end else begin
            rem_q  <= rem_d;
            code_q <= code_d;
            last_q <= last_d;
            tag_q  <= tag_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
         end
      end
   end

   assign out_valid = g_st[STAGES-1].vld_q;
   assign codeout   = g_st[STAGES-1].code_q;
   assign out_tag   = g_st[STAGES-1].tag_q;
   assign out_err   = g_st[STAGES-1].err_q;

   assign unused_tail = ^{g_st[STAGES-1].rem_q, g_st[STAGES-1].last_q};

endmodule

// File: tb/tb_fpf_encoder_pipe.sv
// tb_fpf_encoder_pipe: scoreboard bench driving five encoder builds
// from one stimulus stream; only build 0 sees backpressure.
module tb_fpf_encoder_pipe;

   localparam int NB = 5;
   localparam int CW [NB] = '{42, 42, 42, 4, 5};
   localparam int ST [NB] = '{3, 1, 41, 2, 2};

   logic        clock;
   logic        rst_n;
   logic        drv_valid;
   logic [63:0] drv_data;
   logic [3:0]  drv_tag;
   logic        drv_ready;
   logic        rmode;
   logic        lat_on;
   int          stalls;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic logic [63:0] fib(input int k);
      logic [63:0] a, b, t;
      a = 1;
      b = 1;
      for (int i = 3; i <= k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   function automatic int dw(input int n);
      int w;
      w = 0;
      while ((64'd1 << w) < fib(n + 2)) w++;
      return w;
   endfunction

   function automatic logic [64:0] ref_enc(input int n, input logic [63:0] d);
      logic [63:0] f [0:70];
      logic [63:0] c, r;
      f[0] = 0;
      f[1] = 1;
      f[2] = 1;
      for (int k = 3; k <= n + 2; k++) f[k] = f[k-1] + f[k-2];
      if (d > f[n+2] - 1) return {1'b1, (64'd1 << n) - 64'd1};
      c = 0;
      c[n-1] = (d >= f[n+1]);
      r = c[n-1] ? d - f[n] : d;
      for (int i = n - 2; i >= 1; i--) begin
         if (r < f[i+1])       c[i] = 1'b0;
         else if (r >= f[i+2]) c[i] = 1'b1;
         else                  c[i] = c[i+1];
         if (c[i]) r = r - f[i+1];
      end
      c[0] = r[0];
      return {1'b0, c};
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   for (genvar b = 0; b < NB; b++) begin : g_b
      localparam int  N  = CW[b];
      localparam int  S  = ST[b];
      localparam int  DW = dw(N);
      localparam bit  FREE = (b != 0);

      logic          in_ready, out_valid, out_err, rdy;
      logic [N-1:0]  codeout;
      logic [3:0]    out_tag;
      logic [DW-1:0] din;
      logic [64:0]   q_exp [$];
      logic [3:0]    q_tag [$];
      int            q_cyc [$];
      logic          held = 1'b0;
      logic [N-1:0]  h_code;
      logic [3:0]    h_tag;
      logic          h_err;

      assign din = drv_data[DW-1:0];
      assign rdy = FREE ? 1'b1 : drv_ready;

      fpf_encoder_pipe #(
         .CODE_W (N),
         .STAGES (S),
         .TAG_W  (4)
      ) u_dut (
         .clock     (clock),
         .rst_n     (rst_n),
         .in_valid  (drv_valid),
         .in_ready  (in_ready),
         .datain    (din),
         .in_tag    (drv_tag),
         .out_valid (out_valid),
         .out_ready (rdy),
         .codeout   (codeout),
         .out_tag   (out_tag),
         .out_err   (out_err)
      );

      always @(negedge clock) begin
         logic [64:0] e;
         int          c0;
         if (!rst_n) begin
            q_exp.delete();
            q_tag.delete();
            q_cyc.delete();
            held = 1'b0;
         end else begin
            if (held) begin
               check($sformatf("b%0d hold code", b), 64'(codeout), 64'(h_code));
               check($sformatf("b%0d hold tag", b), 64'(out_tag), 64'(h_tag));
               check($sformatf("b%0d hold err", b), 64'(out_err), 64'(h_err));
            end
            if (out_valid && q_exp.size() == 0) begin
               check($sformatf("b%0d spurious", b), 64'(out_valid), 64'd0);
            end else if (out_valid && rdy) begin
               e  = q_exp.pop_front();
               c0 = q_cyc.pop_front();
               check($sformatf("b%0d code", b), 64'(codeout), e[63:0]);
               check($sformatf("b%0d err", b), 64'(out_err), 64'(e[64]));
               check($sformatf("b%0d tag", b), 64'(out_tag), 64'(q_tag.pop_front()));
               if (lat_on || FREE)
                  check($sformatf("b%0d latency", b), 64'(cyc - c0), 64'(S));
            end
            held   = out_valid && !rdy;
            h_code = codeout;
            h_tag  = out_tag;
            h_err  = out_err;
            if (drv_valid && in_ready) begin
               q_exp.push_back(ref_enc(N, 64'(din)));
               q_tag.push_back(drv_tag);
               q_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      if (rmode) drv_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [63:0] d, input logic [3:0] t);
      int w;
      drv_valid = 1'b1;
      drv_data  = d;
      drv_tag   = t;
      w = 0;
      while (!g_b[0].in_ready && w < 50) begin
         step();
         w++;
         stalls++;
      end
      if (w >= 50) check("send timeout", 64'(w), 64'd0);
      step();
   endtask

   task automatic idle(input int n);
      drv_valid = 1'b0;
      repeat (n) step();
   endtask

   function automatic int pending();
      return g_b[0].q_exp.size() + g_b[1].q_exp.size() +
             g_b[2].q_exp.size() + g_b[3].q_exp.size() +
             g_b[4].q_exp.size();
   endfunction

   task automatic drain();
      int w;
      rmode     = 1'b0;
      drv_ready = 1'b1;
      drv_valid = 1'b0;
      w = 0;
      while (pending() != 0 && w < 300) begin
         step();
         w++;
      end
      check("drain", 64'(pending()), 64'd0);
   endtask

   localparam logic [63:0] MAXV42 = 64'd701408732;

   logic [63:0] hv [9] = '{0, 1, 3, 4, 5, 7, 12, 13, 15};
   logic [3:0]  h4 [9] = '{4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1100,
                           4'b1111, 4'b0111, 4'b1100, 4'b1111};
   logic [4:0]  h5 [9] = '{5'b00000, 5'b00001, 5'b00110, 5'b00111, 5'b01100,
                           5'b01111, 5'b11111, 5'b11111, 5'b11111};
   logic        e5 [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
   logic [63:0] dv [10] = '{0, 1, 2, 701408731, 701408732, 701408733,
                            1073741823, 433494437, 433494436, 267914296};

   initial begin
      drv_valid = 1'b0;
      drv_data  = '0;
      drv_tag   = '0;
      drv_ready = 1'b1;
      rmode     = 1'b0;
      lat_on    = 1'b1;
      stalls    = 0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst out_valid", 64'(g_b[0].out_valid), 64'd0);
      check("rst codeout", 64'(g_b[0].codeout), 64'd0);
      check("rst out_tag", 64'(g_b[0].out_tag), 64'd0);
      check("rst out_err", 64'(g_b[0].out_err), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst in_ready", 64'(g_b[0].in_ready), 64'd1);
      step();

      for (int k = 0; k < 9; k++) begin
         send(hv[k], 4'(k + 3));
         idle(1);
         check("w4 valid", 64'(g_b[3].out_valid), 64'd1);
         check("w4 code", 64'(g_b[3].codeout), 64'(h4[k]));
         check("w5 code", 64'(g_b[4].codeout), 64'(h5[k]));
         check("w5 err", 64'(g_b[4].out_err), 64'(e5[k]));
         check("w5 tag", 64'(g_b[4].out_tag), 64'(k + 3));
      end
      drain();

      for (int k = 0; k < 10; k++) send(dv[k], 4'(k));
      drain();

      stalls = 0;
      for (int k = 0; k < 300; k++)
         send({$urandom, $urandom} % (MAXV42 + 64'd1), 4'($urandom));
      check("throughput stalls", 64'(stalls), 64'd0);
      drain();

      lat_on    = 1'b0;
      drv_ready = 1'b0;
      for (int k = 0; k < 3; k++) send(64'(k * 1000 + 7), 4'(k + 1));
      drv_data = 64'd555;
      drv_tag  = 4'hc;
      for (int k = 0; k < 5; k++) begin
         check("bp in_ready", 64'(g_b[0].in_ready), 64'd0);
         check("bp out_valid", 64'(g_b[0].out_valid), 64'd1);
         step();
      end
      drv_ready = 1'b1;
      send(64'd555, 4'hc);
      for (int k = 0; k < 4; k++) send(64'(k * 77 + 9), 4'(k + 8));
      drain();

      rmode = 1'b1;
      for (int k = 0; k < 150; k++) begin
         send({$urandom, $urandom} % (MAXV42 + 64'd3), 4'($urandom));
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      drain();
      lat_on = 1'b1;

      for (int k = 0; k < 3; k++) send(64'(k + 100), 4'(k));
      drv_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst out_valid", 64'(g_b[0].out_valid), 64'd0);
      check("mid rst codeout", 64'(g_b[0].codeout), 64'd0);
      check("mid rst long valid", 64'(g_b[2].out_valid), 64'd0);
      check("mid rst long code", 64'(g_b[2].codeout), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      send(64'd12345, 4'h9);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
